// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW encoder core and its output code packer.
//   DEFAULT_HASH_WIDTH : default code width in bits, shared with the encoder.
//   packer_state_t     : packer FSM states.
//   bytes_for_codes(n) : number of output bytes produced by n codes once the
//                        final partial byte is padded (ceil(n*width/8)).
package lzw_pkg;

    localparam int DEFAULT_HASH_WIDTH = 12;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PAD  = 2'd1,
        DONE = 2'd2
    } packer_state_t;

    function automatic int bytes_for_codes(input int n);
        return (n * DEFAULT_HASH_WIDTH + 7) / 8;
    endfunction

endpackage

// File: rtl/lzw_code_packer.sv
// LZW output code packer.
// Accepts HASH_WIDTH-bit codes on a valid/ready handshake, packs them LSB-first
// into a bit accumulator and emits the stream as bytes on a second valid/ready
// handshake. A flush pulse drains the accumulator, zero-pads the last partial
// byte and then raises a sticky done.
// Ports:
//   clk, rst                     : clock, synchronous active-low reset
//   code_in/code_valid/code_ready: code input handshake
//   flush                        : end-of-file pulse
//   byte_out/byte_valid/byte_ready: byte output handshake
//   done                         : all bits emitted, sticky until reset
//   byte_count, code_count       : wrapping counters of bytes emitted / codes taken
// Every output is a flop, so nothing on the input side reaches an output in
// the same cycle; during reset all outputs are held low.
module lzw_code_packer
    import lzw_pkg::*;
#(
    parameter int HASH_WIDTH = DEFAULT_HASH_WIDTH,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HASH_WIDTH-1:0] code_in,
    input  logic                  code_valid,
    output logic                  code_ready,
    input  logic                  flush,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic [CNT_WIDTH-1:0]  code_count
);

    localparam int BW = $clog2(ACC_WIDTH + 1);

    packer_state_t          state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_WIDTH-1:0]   code_cnt_q, code_cnt_d;
    logic                   code_ready_q, code_ready_d;
    logic                   byte_valid_q, byte_valid_d;
    logic [7:0]             byte_out_q, byte_out_d;
    logic                   done_q, done_d;

    logic                   pop_s;
    logic                   push_s;
    logic [ACC_WIDTH-1:0]   acc_pop_s;
    logic [BW-1:0]          cnt_pop_s;

    // Next-state logic: pop is applied first so a same-cycle push lands at the
    // post-pop offset, then the FSM and the registered outputs are derived
    // from the resulting next state.
    always_comb begin
        pop_s        = byte_valid_q && byte_ready;
        push_s       = code_valid && code_ready_q;

        acc_pop_s    = acc_q;
        cnt_pop_s    = bit_cnt_q;
        acc_d        = acc_q;
        bit_cnt_d    = bit_cnt_q;
        flush_pend_d = flush_pend_q;
        byte_cnt_d   = byte_cnt_q;
        code_cnt_d   = code_cnt_q;
        state_d      = state_q;

        if (pop_s) begin
            acc_pop_s  = acc_q >> 4'd8;
            byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
            if (state_q == PAD) begin
                cnt_pop_s = '0;
            end else begin
                cnt_pop_s = bit_cnt_q - BW'(8);
            end
        end else begin
            acc_pop_s = acc_q;
            cnt_pop_s = bit_cnt_q;
        end

        if (push_s) begin
            acc_d      = acc_pop_s | (ACC_WIDTH'(code_in) << cnt_pop_s);
            bit_cnt_d  = cnt_pop_s + BW'(HASH_WIDTH);
            code_cnt_d = code_cnt_q + CNT_WIDTH'(1);
        end else begin
            acc_d     = acc_pop_s;
            bit_cnt_d = cnt_pop_s;
        end

        // A flush only counts once, and only while still streaming.
        if (flush && (state_q == RUN) && !flush_pend_q) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_q;
        end

        case (state_q)
            RUN: begin
                if (flush_pend_q && (bit_cnt_d < BW'(8))) begin
                    state_d = PAD;
                end else begin
                    state_d = RUN;
                end
            end
            PAD: begin
                if ((bit_cnt_q == '0) || pop_s) begin
                    state_d = DONE;
                end else begin
                    state_d = PAD;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase

        code_ready_d = (state_d == RUN) && !flush_pend_d &&
                       (bit_cnt_d <= BW'(ACC_WIDTH - HASH_WIDTH));
        byte_valid_d = ((state_d == RUN) && (bit_cnt_d >= BW'(8))) ||
                       ((state_d == PAD) && (bit_cnt_d != '0));
        byte_out_d   = acc_d[7:0];
        done_d       = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            byte_cnt_q   <= '0;
            code_cnt_q   <= '0;
            code_ready_q <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_out_q   <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            flush_pend_q <= flush_pend_d;
            byte_cnt_q   <= byte_cnt_d;
            code_cnt_q   <= code_cnt_d;
            code_ready_q <= code_ready_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            done_q       <= done_d;
        end
    end

    assign code_ready = code_ready_q;
    assign byte_valid = byte_valid_q;
    assign byte_out   = byte_out_q;
    assign done       = done_q;
    assign byte_count = byte_cnt_q;
    assign code_count = code_cnt_q;

endmodule

// File: tb/tb_lzw_code_packer.sv
// Directed testbench for lzw_code_packer: reset state, packing order,
// flush/pad/done sequencing, backpressure, a long randomised stream checked
// against a bit-level reference, and reset in mid-stream.
module tb_lzw_code_packer;
    import lzw_pkg::*;

    localparam int HW = 12;
    localparam int AW = 24;
    localparam int CW = 16;
    localparam int NCODES = 1000;
    localparam int NBYTES = 1500;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [HW-1:0] code_in = '0;
    logic          code_valid = 1'b0;
    logic          code_ready;
    logic          flush = 1'b0;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic          done;
    logic [CW-1:0] byte_count;
    logic [CW-1:0] code_count;

    int vectors = 0;
    int miscompares = 0;
    int pushes = 0;
    logic [7:0]    got[$];
    logic [HW-1:0] codes[NCODES];
    logic [7:0]    expb[NBYTES];

    lzw_code_packer #(.HASH_WIDTH(HW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .flush(flush), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .done(done),
        .byte_count(byte_count), .code_count(code_count)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven: logs the handshakes
    // that the coming rising edge will complete, then advances one cycle.
    task automatic tick();
        if (byte_valid === 1'b1 && byte_ready === 1'b1) got.push_back(byte_out);
        if (code_valid === 1'b1 && code_ready === 1'b1) pushes++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        got.delete();
        pushes = 0;
    endtask

    task automatic wait_bytes(input int n, input int bound);
        int k = 0;
        while (got.size() < n && k < bound) begin
            tick();
            k++;
        end
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
    endtask

    function automatic logic [7:0] gb(input int k);
        if (got.size() > k) return got[k];
        else return 8'hxx;
    endfunction

    initial begin
        @(negedge clk);

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_code_ready", 32'(code_ready), 32'd0);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte_out",   32'(byte_out),   32'd0);
        chk("rst_done",       32'(done),       32'd0);
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        chk("rst_code_count", 32'(code_count), 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_code_ready", 32'(code_ready), 32'd1);
        chk("rel_byte_valid", 32'(byte_valid), 32'd0);

        // Two codes, free-running sink: 0x042041 -> 41 20 04
        got.delete();
        byte_ready = 1'b1;
        code_valid = 1'b1;
        code_in = 12'h041;
        tick();
        code_in = 12'h042;
        tick();
        code_valid = 1'b0;
        wait_bytes(3, 20);
        tick();
        tick();
        chk("t1_nbytes", 32'(got.size()), 32'd3);
        chk("t1_b0", 32'(gb(0)), 32'h41);
        chk("t1_b1", 32'(gb(1)), 32'h20);
        chk("t1_b2", 32'(gb(2)), 32'h04);
        chk("t1_code_count", 32'(code_count), 32'd2);
        chk("t1_byte_count", 32'(byte_count), 32'd3);
        chk("t1_done", 32'(done), 32'd0);

        // One code then flush: BC, 0A padded; done the cycle after the last pop
        do_reset();
        byte_ready = 1'b1;
        code_valid = 1'b1;
        code_in = 12'hABC;
        tick();
        code_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_bytes(2, 20);
        chk("t2_done_after_pop", 32'(done), 32'd1);
        chk("t2_byte_valid_off", 32'(byte_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("t2_nbytes", 32'(got.size()), 32'd2);
        chk("t2_b0", 32'(gb(0)), 32'hBC);
        chk("t2_b1", 32'(gb(1)), 32'h0A);
        chk("t2_byte_count", 32'(byte_count), 32'd2);
        chk("t2_done_sticky", 32'(done), 32'd1);
        chk("t2_code_ready", 32'(code_ready), 32'd0);

        // Even code count, flush with the last push: no pad byte
        do_reset();
        byte_ready = 1'b1;
        code_valid = 1'b1;
        code_in = 12'h041;
        tick();
        code_in = 12'h042;
        flush = 1'b1;
        tick();
        code_valid = 1'b0;
        flush = 1'b0;
        wait_done(30);
        tick();
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_nbytes", 32'(got.size()), 32'd3);
        chk("t3_b0", 32'(gb(0)), 32'h41);
        chk("t3_b1", 32'(gb(1)), 32'h20);
        chk("t3_b2", 32'(gb(2)), 32'h04);
        chk("t3_byte_count", 32'(byte_count), 32'd3);
        chk("t3_code_count", 32'(code_count), 32'd2);

        // Backpressure with 0xFFF codes
        do_reset();
        byte_ready = 1'b0;
        code_valid = 1'b1;
        code_in = 12'hFFF;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_pushes", 32'(pushes), 32'd2);
        chk("t4_code_ready_low", 32'(code_ready), 32'd0);
        chk("t4_byte_valid", 32'(byte_valid), 32'd1);
        chk("t4_byte_out", 32'(byte_out), 32'hFF);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_byte_out_held", 32'(byte_out), 32'hFF);
        chk("t4_byte_valid_held", 32'(byte_valid), 32'd1);
        chk("t4_no_pop", 32'(got.size()), 32'd0);
        code_valid = 1'b0;
        byte_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t4_nbytes", 32'(got.size()), 32'd3);
        chk("t4_b0", 32'(gb(0)), 32'hFF);
        chk("t4_b1", 32'(gb(1)), 32'hFF);
        chk("t4_b2", 32'(gb(2)), 32'hFF);
        chk("t4_byte_count", 32'(byte_count), 32'd3);
        chk("t4_code_ready_back", 32'(code_ready), 32'd1);

        // Long random stream against a bit-level reference
        for (int i = 0; i < NCODES; i++) codes[i] = HW'($urandom);
        for (int k = 0; k < NBYTES; k++) expb[k] = 8'h00;
        for (int i = 0; i < NCODES; i++)
            for (int b = 0; b < HW; b++)
                expb[(i * HW + b) / 8][(i * HW + b) % 8] = codes[i][b];
        do_reset();
        begin
            int idx = 0;
            int cyc = 0;
            bit will_push;
            while (idx < NCODES && cyc < 20000) begin
                code_valid = ($urandom_range(0, 3) != 0);
                code_in = codes[idx];
                byte_ready = $urandom_range(0, 1) == 1;
                will_push = code_valid && code_ready;
                tick();
                if (will_push) idx++;
                cyc++;
            end
            chk("t5_all_codes_taken", 32'(idx), 32'(NCODES));
        end
        code_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        begin
            int k = 0;
            while (done !== 1'b1 && k < 5000) begin
                byte_ready = $urandom_range(0, 1) == 1;
                tick();
                k++;
            end
        end
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_nbytes", 32'(got.size()), 32'(bytes_for_codes(NCODES)));
        chk("t5_byte_count", 32'(byte_count), 32'(bytes_for_codes(NCODES)));
        chk("t5_code_count", 32'(code_count), 32'(NCODES));
        for (int k = 0; k < NBYTES; k++) chk($sformatf("t5_byte%0d", k), 32'(gb(k)), 32'(expb[k]));

        // Reset in mid-stream with 4 bits buffered
        do_reset();
        byte_ready = 1'b1;
        code_valid = 1'b1;
        code_in = 12'hABC;
        tick();
        code_valid = 1'b0;
        tick();
        chk("t6_pre_byte_count", 32'(byte_count), 32'd1);
        chk("t6_pre_code_count", 32'(code_count), 32'd1);
        chk("t6_pre_byte_valid", 32'(byte_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_rst_code_ready", 32'(code_ready), 32'd0);
        chk("t6_rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("t6_rst_byte_out", 32'(byte_out), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_byte_count", 32'(byte_count), 32'd0);
        chk("t6_rst_code_count", 32'(code_count), 32'd0);
        rst = 1'b1;
        tick();
        got.delete();
        code_valid = 1'b1;
        code_in = 12'h123;
        flush = 1'b1;
        tick();
        code_valid = 1'b0;
        flush = 1'b0;
        wait_done(30);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_nbytes", 32'(got.size()), 32'd2);
        chk("t6_b0", 32'(gb(0)), 32'h23);
        chk("t6_b1", 32'(gb(1)), 32'h01);
        chk("t6_byte_count", 32'(byte_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
